// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues word-aligned reads to instruction memory one
// at a time and presents each returned word to decode in an output register.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_gnt_i,
   input  logic        imem_rvalid_i,
   input  logic [31:0] imem_rdata_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   input  logic        stall_i,
   output logic        instr_valid_o,
   output logic [31:0] instr_o,
   output logic [31:0] pc_o,
   output logic [6:0]  opcode_o
);

   typedef enum logic [1:0] {
      S_REQ     = 2'd0,
      S_WAIT    = 2'd1,
      S_DISCARD = 2'd2
   } state_t;

   state_t      state;
   logic [31:0] fetch_pc;
   logic [31:0] req_pc;
   logic        hold;
   logic        consumed;

   assign hold     = instr_valid_o & stall_i;
   assign consumed = instr_valid_o & ~stall_i;

   // Requests go out only when the output register is free to take the answer,
   // so a held instruction can never be overwritten by a later response.
   assign imem_req_o  = (state == S_REQ) & ~hold & ~redirect_i & ~rst_i;
   assign imem_addr_o = fetch_pc;
   assign opcode_o    = instr_o[6:0];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state         <= S_REQ;
         fetch_pc      <= RESET_PC;
         req_pc        <= RESET_PC;
         instr_valid_o <= 1'b0;
         instr_o       <= 32'h0000_0013;
         pc_o          <= RESET_PC;
      end else begin
         if (consumed) begin
            instr_valid_o <= 1'b0;
         end

         if (redirect_i) begin
            fetch_pc      <= redirect_pc_i & ~32'h0000_0003;
            instr_valid_o <= 1'b0;
            // A response still in flight belongs to the old path and must be eaten.
            if (state != S_REQ) begin
               state <= imem_rvalid_i ? S_REQ : S_DISCARD;
            end
         end else begin
            case (state)
               S_REQ: begin
                  if (imem_req_o && imem_gnt_i) begin
                     req_pc   <= fetch_pc;
                     fetch_pc <= fetch_pc + 32'd4;
                     state    <= S_WAIT;
                  end
               end
               S_WAIT: begin
                  if (imem_rvalid_i) begin
                     instr_o       <= imem_rdata_i;
                     pc_o          <= req_pc;
                     instr_valid_o <= 1'b1;
                     state         <= S_REQ;
                  end
               end
               S_DISCARD: begin
                  if (imem_rvalid_i) begin
                     state <= S_REQ;
                  end
               end
               default: state <= S_REQ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a latency-configurable memory model feeds a scoreboard
// of instructions that decode is expected to consume, in order.
module tb_fetch_stage;

   localparam logic [31:0] RST_PC = 32'h0000_0000;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_i = 1'b1, imem_gnt_i = 1'b0, imem_rvalid_i = 1'b0;
   logic        redirect_i = 1'b0, stall_i = 1'b0;
   logic [31:0] imem_rdata_i = '0, redirect_pc_i = '0;
   logic        imem_req_o, instr_valid_o;
   logic [31:0] imem_addr_o, instr_o, pc_o;
   logic [6:0]  opcode_o;

   fetch_stage #(.RESET_PC(RST_PC)) u_dut (
      .clk_i(clk), .rst_i(rst_i),
      .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
      .imem_gnt_i(imem_gnt_i), .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
      .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i), .stall_i(stall_i),
      .instr_valid_o(instr_valid_o), .instr_o(instr_o), .pc_o(pc_o), .opcode_o(opcode_o)
   );

   // Second instance exercising the address wrap from the top of memory.
   logic        w_rst = 1'b1, w_gnt = 1'b0, w_rvalid = 1'b0;
   logic [31:0] w_rdata = '0;
   logic        w_req, w_valid;
   logic [31:0] w_addr, w_instr, w_pc;
   logic [6:0]  w_opcode;

   fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
      .clk_i(clk), .rst_i(w_rst),
      .imem_req_o(w_req), .imem_addr_o(w_addr),
      .imem_gnt_i(w_gnt), .imem_rvalid_i(w_rvalid), .imem_rdata_i(w_rdata),
      .redirect_i(1'b0), .redirect_pc_i(32'h0), .stall_i(1'b0),
      .instr_valid_o(w_valid), .instr_o(w_instr), .pc_o(w_pc), .opcode_o(w_opcode)
   );

   int          n_cmp = 0, n_err = 0;
   bit          mem_pending = 0, mem_doomed = 0;
   int          mem_delay = 0, lat = 0, n_granted = 0;
   logic [31:0] mem_addr = '0, exp_addr = RST_PC;
   logic [63:0] sb[$];
   logic [31:0] consumed_pcs[$];
   bit          last_req;
   logic [31:0] last_addr;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[24:0], 7'h33};
   endfunction

   // One clock cycle: drive inputs and the memory model on the falling edge,
   // check, then advance the model on the rising edge.
   task automatic tick(input bit r, input bit redir, input logic [31:0] rpc,
                       input bit st, input bit gnt);
      logic [63:0] e;
      bit          rv;
      @(negedge clk);
      rst_i = r; redirect_i = redir; redirect_pc_i = rpc; stall_i = st; imem_gnt_i = gnt;
      rv = mem_pending && (mem_delay == 0);
      imem_rvalid_i = rv;
      imem_rdata_i  = rv ? mem_word(mem_addr) : $urandom;
      if (rv && !mem_doomed && !redir && !r) sb.push_back({mem_addr, mem_word(mem_addr)});
      #1;
      last_req = imem_req_o; last_addr = imem_addr_o;
      if (!r) begin
         if (mem_pending || (instr_valid_o && st) || redir) begin
            n_cmp++;
            if (imem_req_o !== 1'b0) begin
               n_err++; $display("FAIL req_blocked: imem_req_o=%b required 0", imem_req_o);
            end
         end
         if (imem_req_o === 1'b1) begin
            n_cmp++;
            if (imem_addr_o !== exp_addr) begin
               n_err++; $display("FAIL req_addr: got %h required %h", imem_addr_o, exp_addr);
            end
         end
         if (instr_valid_o && !st) begin
            n_cmp++;
            if (sb.size() == 0) begin
               n_err++; $display("FAIL unexpected_instr: pc %h instr %h, none expected", pc_o, instr_o);
            end else begin
               e = sb.pop_front();
               if ({pc_o, instr_o} !== e || opcode_o !== e[6:0]) begin
                  n_err++;
                  $display("FAIL consume: got pc %h instr %h op %h required pc %h instr %h op %h",
                           pc_o, instr_o, opcode_o, e[63:32], e[31:0], e[6:0]);
               end
            end
            consumed_pcs.push_back(pc_o);
         end
      end
      @(posedge clk);
      if (rv) mem_pending = 0;
      else if (mem_pending) mem_delay--;
      if (r) begin
         sb.delete(); exp_addr = RST_PC; mem_doomed = 1;
      end else if (redir) begin
         exp_addr = rpc & ~32'h3;
         if (mem_pending) mem_doomed = 1;
      end else if (last_req && gnt) begin
         mem_pending = 1; mem_doomed = 0; mem_addr = last_addr; mem_delay = lat;
         exp_addr = last_addr + 32'd4; n_granted++;
      end
      #1;
   endtask

   task automatic drain();
      for (int c = 0; c < 20 && (mem_pending || instr_valid_o); c++) tick(0, 0, 0, 0, 0);
      n_cmp++;
      if (mem_pending || instr_valid_o) begin
         n_err++; $display("FAIL drain_timeout: pending=%b valid=%b required 0 0", mem_pending, instr_valid_o);
      end
   endtask

   task automatic check_next_req(input string name, input logic [31:0] want);
      tick(0, 0, 0, 0, 0);
      n_cmp++;
      if (last_req !== 1'b1 || last_addr !== want) begin
         n_err++; $display("FAIL %s: req=%b addr=%h required req=1 addr=%h", name, last_req, last_addr, want);
      end
   endtask

   task automatic test_reset();
      tick(1, 0, 0, 0, 0);
      tick(1, 0, 0, 0, 0);
      n_cmp++;
      if (instr_valid_o !== 1'b0 || instr_o !== 32'h13 || pc_o !== RST_PC ||
          opcode_o !== 7'h13 || imem_req_o !== 1'b0) begin
         n_err++;
         $display("FAIL reset_state: valid=%b instr=%h pc=%h op=%h req=%b required 0 00000013 %h 13 0",
                  instr_valid_o, instr_o, pc_o, opcode_o, imem_req_o, RST_PC);
      end
   endtask

   task automatic test_first_fetch();
      lat = 0;
      tick(0, 0, 0, 0, 1);
      n_cmp++;
      if (last_req !== 1'b1 || last_addr !== RST_PC) begin
         n_err++; $display("FAIL first_req: req=%b addr=%h required 1 %h", last_req, last_addr, RST_PC);
      end
      tick(0, 0, 0, 0, 0);
      n_cmp++;
      if (instr_valid_o !== 1'b1 || pc_o !== 32'h0 || opcode_o !== 7'h33 || instr_o !== 32'h33) begin
         n_err++;
         $display("FAIL first_instr: valid=%b pc=%h op=%h instr=%h required 1 00000000 33 00000033",
                  instr_valid_o, pc_o, opcode_o, instr_o);
      end
      check_next_req("second_req", 32'h4);
      drain();
   endtask

   task automatic test_stream_stall();
      int          base_g, stalls;
      bit          st;
      logic [31:0] held_i, held_p;
      drain();
      tick(1, 0, 0, 0, 0);
      consumed_pcs.delete();
      base_g = n_granted; stalls = 0; lat = 0; held_i = '0; held_p = '0;
      for (int c = 0; c < 60 && consumed_pcs.size() < 4; c++) begin
         st = instr_valid_o && (consumed_pcs.size() == 1) && (stalls < 3);
         if (st) begin
            if (stalls == 0) begin
               held_i = instr_o; held_p = pc_o;
            end else begin
               n_cmp++;
               if (instr_o !== held_i || pc_o !== held_p || instr_valid_o !== 1'b1) begin
                  n_err++; $display("FAIL stall_hold: instr=%h pc=%h required %h %h", instr_o, pc_o, held_i, held_p);
               end
            end
            stalls++;
         end
         tick(0, 0, 0, st, (n_granted - base_g) < 4);
      end
      n_cmp++;
      if (consumed_pcs.size() != 4 || stalls != 3) begin
         n_err++; $display("FAIL stream_count: consumed=%0d stalls=%0d required 4 3", consumed_pcs.size(), stalls);
      end
      for (int i = 0; i < consumed_pcs.size(); i++) begin
         n_cmp++;
         if (consumed_pcs[i] !== 32'(4 * i)) begin
            n_err++; $display("FAIL stream_pc%0d: got %h required %h", i, consumed_pcs[i], 32'(4 * i));
         end
      end
      drain();
   endtask

   task automatic test_redirect_wait();
      drain();
      lat = 2;
      tick(0, 0, 0, 0, 1);
      tick(0, 1, 32'h0000_0103, 0, 0);
      tick(0, 0, 0, 0, 0);
      tick(0, 0, 0, 0, 0);
      n_cmp++;
      if (instr_valid_o !== 1'b0) begin
         n_err++; $display("FAIL redirect_wait_valid: got %b required 0", instr_valid_o);
      end
      check_next_req("redirect_wait_addr", 32'h0000_0100);
   endtask

   task automatic test_redirect_rvalid();
      drain();
      lat = 0;
      tick(0, 0, 0, 0, 1);
      tick(0, 1, 32'h0000_0207, 0, 0);
      n_cmp++;
      if (instr_valid_o !== 1'b0) begin
         n_err++; $display("FAIL redirect_rvalid_valid: got %b required 0", instr_valid_o);
      end
      check_next_req("redirect_rvalid_addr", 32'h0000_0204);
   endtask

   task automatic test_reset_in_wait();
      drain();
      lat = 0;
      tick(0, 0, 0, 0, 1);
      tick(1, 0, 0, 0, 0);
      n_cmp++;
      if (instr_valid_o !== 1'b0 || pc_o !== RST_PC) begin
         n_err++; $display("FAIL reset_wait_valid: valid=%b pc=%h required 0 %h", instr_valid_o, pc_o, RST_PC);
      end
      check_next_req("reset_wait_addr", RST_PC);
   endtask

   task automatic test_wrap();
      @(negedge clk); w_rst = 1'b1;
      @(posedge clk); #1;
      n_cmp++;
      if (w_pc !== 32'hFFFF_FFFC || w_valid !== 1'b0) begin
         n_err++; $display("FAIL wrap_reset: pc=%h valid=%b required fffffffc 0", w_pc, w_valid);
      end
      @(negedge clk); w_rst = 1'b0; w_gnt = 1'b1; #1;
      n_cmp++;
      if (w_req !== 1'b1 || w_addr !== 32'hFFFF_FFFC) begin
         n_err++; $display("FAIL wrap_req0: req=%b addr=%h required 1 fffffffc", w_req, w_addr);
      end
      @(posedge clk);
      @(negedge clk); w_gnt = 1'b0; w_rvalid = 1'b1; w_rdata = 32'h0000_0013;
      @(posedge clk);
      @(negedge clk); w_rvalid = 1'b0; w_gnt = 1'b1; #1;
      n_cmp++;
      if (w_valid !== 1'b1 || w_pc !== 32'hFFFF_FFFC || w_req !== 1'b1 || w_addr !== 32'h0) begin
         n_err++;
         $display("FAIL wrap_req1: valid=%b pc=%h req=%b addr=%h required 1 fffffffc 1 00000000",
                  w_valid, w_pc, w_req, w_addr);
      end
      @(posedge clk);
      @(negedge clk); w_gnt = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_first_fetch();
      test_stream_stall();
      test_redirect_wait();
      test_redirect_rvalid();
      test_reset_in_wait();
      test_wrap();
      drain();
      n_cmp++;
      if (sb.size() != 0) begin
         n_err++; $display("FAIL sb_empty: %0d entries left, required 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
